// File: rtl/log2_pkg.sv
// Shared format constants and FSM encoding for the log2 unit and the pow-2 exponent block.
package log2_pkg;

    localparam int unsigned LOG2_W     = 16;
    localparam int unsigned LOG2_INT_W = 3;
    localparam int unsigned LOG2_FRC_W = 12;

    // Most negative representable result, used for zero and underflow clamps.
    localparam logic [LOG2_W-1:0] Y_MIN = {1'b1, {(LOG2_W-1){1'b0}}};

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_NORM = 2'd1;
    localparam state_t ST_FRAC = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // Signed exponent register width for a W-bit operand.
    function automatic int unsigned exp_width(input int unsigned w);
        return $clog2(w) + 2;
    endfunction

endpackage

// File: rtl/log2_unit_if.sv
// Operand/result handshake bundle of the log2 unit.
interface log2_unit_if
    import log2_pkg::*;
#(
    parameter int unsigned W = LOG2_W
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         zero_err;
    logic         sat;

    modport master (
        output in_valid, x, out_ready,
        input  in_ready, out_valid, y, zero_err, sat
    );

    modport slave (
        input  in_valid, x, out_ready,
        output in_ready, out_valid, y, zero_err, sat
    );
endinterface

// File: rtl/log2_frac_step.sv
// One squaring step: m in Q1.(W-1) within [1,2), returns next m and one fraction bit.
module log2_frac_step
    import log2_pkg::*;
#(
    parameter int unsigned W = LOG2_W
) (
    input  logic [W-1:0] m_i,
    output logic [W-1:0] m_o,
    output logic         bit_o
);
    localparam int unsigned PW = 2 * W;

    logic [PW-1:0] p;
    logic          p_unused_lo;

    assign p = PW'(m_i) * PW'(m_i);

    // m^2 >= 2 yields a 1 bit and renormalizes by an extra halving; both paths truncate.
    assign bit_o = p[PW-1];
    assign m_o   = p[PW-1] ? p[PW-1:W] : p[PW-2:W-1];

    assign p_unused_lo = ^p[W-2:0];
endmodule

// File: rtl/log2_unit.sv
// Sequential fixed-point log2: normalize by left shifts, then extract fraction bits by squaring.
// Define LOG2_MITCHELL_EN to replace the squaring loop with Mitchell's linear approximation.
module log2_unit
    import log2_pkg::*;
#(
    parameter int unsigned W     = LOG2_W,
    parameter int unsigned INT_W = LOG2_INT_W,
    parameter int unsigned FRC_W = LOG2_FRC_W
) (
    input  logic      clk,
    input  logic      rst,
    log2_unit_if.slave bus
);
    localparam int unsigned EW       = exp_width(W);
    localparam int unsigned CW       = $clog2(FRC_W);
    localparam int          E_MIN_I  = -(2 ** int'(INT_W));
    localparam logic signed [EW-1:0] E_INIT = EW'(W - 1 - FRC_W);
    localparam logic signed [EW-1:0] E_MIN  = EW'(E_MIN_I);
    localparam logic [W-1:0] Y_MIN_W = {1'b1, {(W-1){1'b0}}};

    state_t                 state_q, state_d;
    logic [W-1:0]           m_q, m_d;
    logic signed [EW-1:0]   e_q, e_d;
    logic [W-1:0]           y_q, y_d;
    logic                   zero_err_q, zero_err_d;
    logic                   sat_q, sat_d;
    logic                   in_ready_q;
    logic                   out_valid_q;

    logic [FRC_W-1:0]       frac_fin;
    logic [W-1:0]           r_fin;
    logic                   sat_fin;

`ifdef LOG2_MITCHELL_EN
    assign frac_fin = m_q[W-2 -: FRC_W];
`else
    logic [FRC_W-2:0]       frac_q, frac_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [W-1:0]           step_m;
    logic                   step_bit;

    log2_frac_step #(.W(W)) u_step (
        .m_i   (m_q),
        .m_o   (step_m),
        .bit_o (step_bit)
    );

    assign frac_fin = {frac_q, step_bit};
`endif

    // Final result as seen when leaving the fraction phase.
    assign r_fin   = {e_q[INT_W:0], frac_fin};
    assign sat_fin = (e_q < E_MIN);

    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        e_d        = e_q;
        y_d        = y_q;
        zero_err_d = zero_err_q;
        sat_d      = sat_q;
`ifndef LOG2_MITCHELL_EN
        frac_d     = frac_q;
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    m_d     = bus.x;
                    e_d     = E_INIT;
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                if (m_q == '0) begin
                    state_d    = ST_DONE;
                    y_d        = Y_MIN_W;
                    zero_err_d = 1'b1;
                    sat_d      = 1'b1;
                end else if (m_q[W-1]) begin
`ifdef LOG2_MITCHELL_EN
                    state_d    = ST_DONE;
                    zero_err_d = 1'b0;
                    sat_d      = sat_fin;
                    y_d        = sat_fin ? Y_MIN_W : r_fin;
`else
                    state_d    = ST_FRAC;
                    cnt_d      = '0;
                    frac_d     = '0;
`endif
                end else begin
                    m_d = m_q << 1;
                    e_d = e_q - EW'(1);
                end
            end
`ifndef LOG2_MITCHELL_EN
            ST_FRAC: begin
                m_d    = step_m;
                frac_d = frac_fin[FRC_W-2:0];
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(FRC_W - 1)) begin
                    state_d    = ST_DONE;
                    zero_err_d = 1'b0;
                    sat_d      = sat_fin;
                    y_d        = sat_fin ? Y_MIN_W : r_fin;
                end
            end
`endif
            ST_DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result registers settle on entry to DONE; out_valid follows one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            m_q         <= '0;
            e_q         <= '0;
            y_q         <= '0;
            zero_err_q  <= 1'b0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifndef LOG2_MITCHELL_EN
            frac_q      <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            e_q         <= e_d;
            y_q         <= y_d;
            zero_err_q  <= zero_err_d;
            sat_q       <= sat_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_q == ST_DONE) && (state_d == ST_DONE);
`ifndef LOG2_MITCHELL_EN
            frac_q      <= frac_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.zero_err  = zero_err_q;
    assign bus.sat       = sat_q;
endmodule

// File: tb/tb_log2_unit.sv
// Self-checking bench for log2_unit against a bit-true arithmetic model of log2.
module tb_log2_unit;
    localparam int unsigned TW = 16;
    localparam int unsigned TI = 3;
    localparam int unsigned TF = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    log2_unit_if #(.W(TW)) bus ();

    log2_unit #(.W(TW), .INT_W(TI), .FRC_W(TF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: log2 from the position of the leading one plus truncated squaring of the mantissa.
    function automatic void ref_log2(input logic [15:0] xv, output logic [15:0] yv,
                                     output logic ze, output logic st, output int lat);
        longint m;
        int     k;
        int     e;
        int     frac;
        if (xv == 16'h0000) begin
            yv = 16'h8000; ze = 1'b1; st = 1'b1; lat = 2;
            return;
        end
        k = 0;
        for (int i = 0; i < 16; i++) if (xv[i]) k = i;
        m = longint'(xv) << (15 - k);
        e = k - int'(TF);
        frac = 0;
`ifdef LOG2_MITCHELL_EN
        frac = int'((m >> 3) & 64'hFFF);
        lat  = (15 - k) + 2;
`else
        for (int i = 0; i < int'(TF); i++) begin
            m = m * m;
            if (m >= (64'sd1 <<< 31)) begin
                frac = frac * 2 + 1;
                m    = m >> 16;
            end else begin
                frac = frac * 2;
                m    = m >> 15;
            end
        end
        lat = (15 - k) + 14;
`endif
        ze = 1'b0;
        if (e < -8) begin
            yv = 16'h8000; st = 1'b1;
        end else begin
            yv = 16'(e * 4096 + frac); st = 1'b0;
        end
    endfunction

    // Issue one operand, wait for its result, optionally stall, then consume it.
    task automatic do_op(input logic [15:0] xv, input int hold, output logic [15:0] yv,
                         output logic ze, output logic st, output int lat);
        logic [15:0] y0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_before_op x=%h got=%b exp=1", xv, bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.x        = xv;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat >= 100) begin
            errors++;
            $display("FAIL timeout x=%h got=no out_valid exp=out_valid within 100 cycles", xv);
        end
        yv = bus.y; ze = bus.zero_err; st = bus.sat;
        y0 = bus.y;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.y !== y0) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got=v%b r%b y%h exp=v1 r0 y%h",
                         i, bus.out_valid, bus.in_ready, bus.y, y0);
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL consume got=v%b r%b exp=v0 r1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic check_op(input string name, input logic [15:0] xv, input int hold);
        logic [15:0] yg, ye;
        logic        zg, ze, sg, se;
        int          lg, le;
        ref_log2(xv, ye, ze, se, le);
        do_op(xv, hold, yg, zg, sg, lg);
        checks++;
        if (yg !== ye || zg !== ze || sg !== se) begin
            errors++;
            $display("FAIL %s x=%h got=y%h z%b s%b exp=y%h z%b s%b", name, xv, yg, zg, sg, ye, ze, se);
        end
        checks++;
        if (lg !== le) begin
            errors++;
            $display("FAIL %s_latency x=%h got=%0d exp=%0d", name, xv, lg, le);
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.x = '0; bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.y !== 16'h0000 ||
            bus.zero_err !== 1'b0 || bus.sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got=r%b v%b y%h z%b s%b exp=r1 v0 y0000 z0 s0",
                     bus.in_ready, bus.out_valid, bus.y, bus.zero_err, bus.sat);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [15:0] yg;
        logic        zg, sg;
        int          lg;
        logic [15:0] tbl [6] = '{16'h1000, 16'h8000, 16'h2000, 16'h0000, 16'h0010, 16'h0001};
        for (int i = 0; i < 6; i++) check_op("directed", tbl[i], 0);
        do_op(16'h1800, 0, yg, zg, sg, lg);
        checks++;
`ifdef LOG2_MITCHELL_EN
        if (yg !== 16'h0800) begin
            errors++;
            $display("FAIL log2_1p5 got=%h exp=0800", yg);
        end
`else
        if (yg !== 16'h095B && yg !== 16'h095C) begin
            errors++;
            $display("FAIL log2_1p5 got=%h exp=095B or 095C", yg);
        end
`endif
    endtask

    task automatic test_random();
        logic [15:0] xv;
        for (int i = 0; i < 40; i++) begin
            xv = 16'($urandom) >> $urandom_range(0, 15);
            if ($urandom_range(0, 19) == 0) xv = '0;
            check_op("random", xv, 0);
        end
    endtask

    task automatic test_backpressure();
        check_op("stall", 16'h2000, 5);
        check_op("stall_neg", 16'h0123, 3);
    endtask

    task automatic test_reset_mid_op();
`ifdef LOG2_MITCHELL_EN
        logic [15:0] xv = 16'h0004;
`else
        logic [15:0] xv = 16'h8000;
`endif
        @(negedge clk);
        bus.in_valid = 1'b1; bus.x = xv;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_op got=r%b v%b exp=r1 v0", bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        check_op("after_reset", 16'h3456, 0);
    endtask

    task automatic test_back_to_back();
        check_op("b2b", 16'hFFFF, 0);
        check_op("b2b", 16'h0000, 0);
        check_op("b2b", 16'h0ABC, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/log2_unit.md
# log2_unit

Sequential fixed-point base-2 logarithm unit for the neuron datapath. It is the inverse of the pow-2 exponent block: it takes an unsigned fixed-point magnitude and returns `log2(x)` in the same signed Q-format the pow-2 block consumes. It normalizes the operand by iterative left shifts, then extracts fractional bits by iterative squaring. Input and output each use a valid/ready handshake.

## Interface
- `W`, 16, total data width; must equal `1 + INT_W + FRC_W`.
- `INT_W`, 3, integer bits of the signed output, sign excluded.
- `FRC_W`, 12, fractional bits of both input and output.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  unit idle and able to accept.
- `x`  in  W  unsigned operand, `FRC_W` fractional bits.
- `out_valid`  out  1  result valid; held until consumed.
- `out_ready`  in  1  consumer accepts the result.
- `y`  out  W  two's-complement `log2(x)`, `FRC_W` fractional bits.
- `zero_err`  out  1  the operand was 0; qualified by `out_valid`.
- `sat`  out  1  the result was clamped to the minimum; qualified by `out_valid`.

## Operation
- The FSM has four states: IDLE, NORM, FRAC, DONE.
- **IDLE**
  - `in_ready` is 1.
  - On `in_valid`, latch `m <= x` and set exponent `e <= W-1-FRC_W` (signed, `$clog2(W)+2` bits). Go to NORM.
- **NORM**, one step per cycle:
  - If `m == 0`: go to DONE with `y = 1<<(W-1)` (0x8000), `zero_err = 1`, `sat = 1`.
  - Else if `m[W-1] == 1`: go to FRAC and clear the fraction counter.
  - Else: `m <= m << 1`, `e <= e - 1`.
- **FRAC**, one fractional bit per cycle, MSB first, `FRC_W` cycles:
  - Treat `m` as Q1.(W-1) in the range [1,2). Compute `p = m*m` (2W bits).
  - If `p[2W-1]` is set, the fraction bit is 1 and `m <= p[2W-1:W]`.
  - Otherwise the fraction bit is 0 and `m <= p[2W-2:W-1]`.
  - Truncate in both cases; there is no rounding.
- **Leaving FRAC**: assemble `r = (e << FRC_W) | frac`.
  - If `e < -(2^INT_W)`, force `y = 0x8000` and `sat = 1`.
  - Otherwise `y = r` and `sat = 0`. The case `e == -(2^INT_W)` is exact and does not set `sat`.
  - Go to DONE.
- **DONE**
  - `out_valid` is 1, and `y`, `zero_err`, `sat` are stable.
  - On `out_ready`, go to IDLE.
- Because `in_ready` is 0 outside IDLE, a new operand cannot be accepted in the cycle a result is consumed.
- `rst` in any state forces IDLE on the next edge and abandons the operation in flight.
- Reset values: `in_ready = 1`, `out_valid = 0`, `y = 0`, `zero_err = 0`, `sat = 0`, state IDLE.

## Timing
- Let `lz` be the leading-zero count of `x` (0..W-1), and let the operand be accepted at edge t.
- For nonzero `x`, `out_valid` rises at edge `t + lz + FRC_W + 2`. With default parameters that is 14 to 29 cycles.
- For `x == 0`, `out_valid` rises at edge `t + 2`.
- There is no pipelining; throughput is one operation per latency plus at least one IDLE cycle.
- All outputs are registered. `in_ready` and `out_valid` are decoded from the registered state.

## Configuration
- `LOG2_MITCHELL_EN`
  - **Defined:** the FRAC state is skipped. NORM exits directly to DONE with `frac = m[W-2:W-1-FRC_W]` (Mitchell linear approximation).
    - Nonzero latency becomes `lz + 2`.
    - The squaring multiplier is not instantiated.
    - Saturation rules are unchanged.
  - **Undefined (default):** iterative squaring as described above.

## Structure
- **`log2_pkg`** holds:
  - the FSM state enum;
  - default `W`, `INT_W`, `FRC_W`;
  - the `Y_MIN` constant (`1<<(W-1)`);
  - the exponent width function.
  - The pow-2 block shares the format constants from this package.
- **`log2_frac_step`** is a combinational sub-module: `m` in, next `m` and fraction bit out. It contains the only multiplier and is omitted under `LOG2_MITCHELL_EN`.

## Test plan
- `x = 0x1000` (1.0) → `y = 0x0000`, `sat = 0`, `zero_err = 0`, `out_valid` at acceptance + 17.
- `x = 0x8000` (8.0) → `y = 0x3000` at acceptance + 14; `x = 0x2000` → `y = 0x1000`.
- `x = 0x1800` (1.5) → `y` within ±1 LSB of 0x095C (0x095B or 0x095C acceptable; exact value matches a bit-true truncating model). With `LOG2_MITCHELL_EN` defined → `y = 0x0800`.
- `x = 0x0000` → `y = 0x8000`, `zero_err = 1`, `sat = 1`, at acceptance + 2.
- `x = 0x0010` (2^-8) → `y = 0x8000`, `sat = 0`. `x = 0x0001` → `y = 0x8000`, `sat = 1`.
- Backpressure and reset:
  - Hold `out_ready = 0` for 5 cycles in DONE → `y` stable and `in_ready = 0` throughout.
  - Assert `rst` mid-FRAC → next cycle shows `in_ready = 1`, `out_valid = 0`.
  - A fresh operand is then processed correctly.
